// File: rtl/mmul_index_sequencer.sv
// rtl/mmul_index_sequencer.sv - i/j/k index beat generator for matrix multiply; MMUL_SEQ_ACC_EN adds acc_clr/acc_commit
module mmul_index_sequencer #(
    parameter int RA = 0,
    parameter int CA = 0,
    parameter int RB = 0,
    parameter int CB = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        ready,
    output logic        valid,
    output logic [31:0] i,
    output logic [31:0] j,
    output logic [31:0] k,
    output logic        last,
    output logic        busy,
    output logic        done
`ifdef MMUL_SEQ_ACC_EN
    ,
    output logic        acc_clr,
    output logic        acc_commit
`endif
);

    localparam logic [31:0] RA_M1 = 32'(RA) - 32'd1;
    localparam logic [31:0] RB_M1 = 32'(RB) - 32'd1;
    localparam logic [31:0] CB_M1 = 32'(CB) - 32'd1;
    // A mismatched inner dimension cannot be multiplied, so it is swept like an empty matrix.
    localparam bit DEGEN      = (RA == 0) || (RB == 0) || (CB == 0) || (CA != RB);
    localparam bit FIRST_LAST = (RA == 1) && (RB == 1) && (CB == 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      state_q;
    logic        valid_q, last_q, busy_q, done_q;
    logic [31:0] i_q, j_q, k_q;
    logic [31:0] i_d, j_d, k_d;
    logic        k_wrap, j_wrap, last_d;
`ifdef MMUL_SEQ_ACC_EN
    logic        acc_clr_q, acc_commit_q;
`endif

    always_comb begin
        k_wrap = (k_q == RB_M1);
        j_wrap = (j_q == CB_M1);
        k_d    = k_wrap ? 32'd0 : k_q + 32'd1;
        j_d    = k_wrap ? (j_wrap ? 32'd0 : j_q + 32'd1) : j_q;
        i_d    = (k_wrap && j_wrap) ? i_q + 32'd1 : i_q;
        last_d = (i_d == RA_M1) && (j_d == CB_M1) && (k_d == RB_M1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            i_q          <= 32'd0;
            j_q          <= 32'd0;
            k_q          <= 32'd0;
`ifdef MMUL_SEQ_ACC_EN
            acc_clr_q    <= 1'b0;
            acc_commit_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        i_q <= 32'd0;
                        j_q <= 32'd0;
                        k_q <= 32'd0;
                        if (DEGEN) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q      <= S_RUN;
                            valid_q      <= 1'b1;
                            busy_q       <= 1'b1;
                            last_q       <= FIRST_LAST;
`ifdef MMUL_SEQ_ACC_EN
                            acc_clr_q    <= 1'b1;
                            acc_commit_q <= (RB == 1);
`endif
                        end
                    end
                end
                S_RUN: begin
                    if (abort || (valid_q && ready && last_q)) begin
                        state_q      <= abort ? S_IDLE : S_DONE;
                        done_q       <= !abort;
                        valid_q      <= 1'b0;
                        last_q       <= 1'b0;
                        busy_q       <= 1'b0;
                        i_q          <= 32'd0;
                        j_q          <= 32'd0;
                        k_q          <= 32'd0;
`ifdef MMUL_SEQ_ACC_EN
                        acc_clr_q    <= 1'b0;
                        acc_commit_q <= 1'b0;
`endif
                    end else if (valid_q && ready) begin
                        i_q          <= i_d;
                        j_q          <= j_d;
                        k_q          <= k_d;
                        last_q       <= last_d;
`ifdef MMUL_SEQ_ACC_EN
                        acc_clr_q    <= (k_d == 32'd0);
                        acc_commit_q <= (k_d == RB_M1);
`endif
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign valid = valid_q;
    assign i     = i_q;
    assign j     = j_q;
    assign k     = k_q;
    assign last  = last_q;
    assign busy  = busy_q;
    assign done  = done_q;
`ifdef MMUL_SEQ_ACC_EN
    assign acc_clr    = acc_clr_q;
    assign acc_commit = acc_commit_q;
`endif

endmodule

// File: tb/tb_mmul_index_sequencer.sv
// tb/tb_mmul_index_sequencer.sv - directed bench for mmul_index_sequencer across several shapes
module tb_mmul_index_sequencer;

    logic clk = 1'b0;
    logic rst_n, start, abort, ready;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    logic        a_valid, a_last, a_busy, a_done;
    logic [31:0] a_i, a_j, a_k;
    logic        b_valid, b_last, b_busy, b_done;
    logic [31:0] b_i, b_j, b_k;
    logic        c_valid, c_last, c_busy, c_done;
    logic [31:0] c_i, c_j, c_k;
    logic        d_valid, d_last, d_busy, d_done;
    logic [31:0] d_i, d_j, d_k;
`ifdef MMUL_SEQ_ACC_EN
    logic        a_clr, a_com, b_clr, b_com, c_clr, c_com, d_clr, d_com;
`endif

    mmul_index_sequencer #(.RA(2), .CA(3), .RB(3), .CB(2)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ready(ready),
        .valid(a_valid), .i(a_i), .j(a_j), .k(a_k), .last(a_last), .busy(a_busy), .done(a_done)
`ifdef MMUL_SEQ_ACC_EN
        , .acc_clr(a_clr), .acc_commit(a_com)
`endif
    );
    mmul_index_sequencer #(.RA(1), .CA(1), .RB(1), .CB(1)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ready(ready),
        .valid(b_valid), .i(b_i), .j(b_j), .k(b_k), .last(b_last), .busy(b_busy), .done(b_done)
`ifdef MMUL_SEQ_ACC_EN
        , .acc_clr(b_clr), .acc_commit(b_com)
`endif
    );
    mmul_index_sequencer u_c (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ready(ready),
        .valid(c_valid), .i(c_i), .j(c_j), .k(c_k), .last(c_last), .busy(c_busy), .done(c_done)
`ifdef MMUL_SEQ_ACC_EN
        , .acc_clr(c_clr), .acc_commit(c_com)
`endif
    );
    mmul_index_sequencer #(.RA(1), .CA(3), .RB(3), .CB(2)) u_d (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ready(ready),
        .valid(d_valid), .i(d_i), .j(d_j), .k(d_k), .last(d_last), .busy(d_busy), .done(d_done)
`ifdef MMUL_SEQ_ACC_EN
        , .acc_clr(d_clr), .acc_commit(d_com)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        ready = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        ready = 1'b0;
        step();
        checks++;
        if ({a_valid, a_last, a_busy, a_done} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got %b exp 0000", {a_valid, a_last, a_busy, a_done});
        end
        checks++;
        if ({a_i, a_j, a_k} !== 96'd0) begin
            failures++;
            $display("FAIL reset_idx got %h exp 0", {a_i, a_j, a_k});
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_sweep();
        logic [98:0] exp_v;
        do_reset();
        ready = 1'b1;
        pulse_start();
        for (int b = 0; b < 12; b++) begin
            exp_v = {1'b1, (b == 11), 1'b1, 32'(b / 6), 32'((b / 3) % 2), 32'(b % 3)};
            checks++;
            if ({a_valid, a_last, a_busy, a_i, a_j, a_k} !== exp_v) begin
                failures++;
                $display("FAIL sweep_beat%0d got %h exp %h", b, {a_valid, a_last, a_busy, a_i, a_j, a_k}, exp_v);
            end
            step();
        end
        checks++;
        if ({a_done, a_valid, a_busy} !== 3'b100) begin
            failures++;
            $display("FAIL sweep_done got %b exp 100", {a_done, a_valid, a_busy});
        end
        step();
        checks++;
        if ({a_done, a_valid, a_busy} !== 3'b000) begin
            failures++;
            $display("FAIL sweep_idle got %b exp 000", {a_done, a_valid, a_busy});
        end
    endtask

    task automatic test_ready_toggle();
        logic [97:0] exp_v;
        int b = 0;
        do_reset();
        ready = 1'b1;
        pulse_start();
        for (int cyc = 0; cyc < 23; cyc++) begin
            exp_v = {1'b1, (b == 11), 32'(b / 6), 32'((b / 3) % 2), 32'(b % 3)};
            checks++;
            if ({a_valid, a_last, a_i, a_j, a_k} !== exp_v) begin
                failures++;
                $display("FAIL toggle_cyc%0d got %h exp %h", cyc, {a_valid, a_last, a_i, a_j, a_k}, exp_v);
            end
            ready = (cyc % 2 == 0);
            step();
            if (cyc % 2 == 0) b++;
        end
        checks++;
        if ({a_done, a_valid} !== 2'b10) begin
            failures++;
            $display("FAIL toggle_done got %b exp 10", {a_done, a_valid});
        end
    endtask

    task automatic test_single();
        do_reset();
        ready = 1'b0;
        pulse_start();
        checks++;
        if ({b_valid, b_last, b_busy, b_i, b_j, b_k} !== {3'b111, 96'd0}) begin
            failures++;
            $display("FAIL single_beat got %h exp %h", {b_valid, b_last, b_busy, b_i, b_j, b_k}, {3'b111, 96'd0});
        end
        ready = 1'b1;
        step();
        checks++;
        if ({b_done, b_valid, b_busy} !== 3'b100) begin
            failures++;
            $display("FAIL single_done got %b exp 100", {b_done, b_valid, b_busy});
        end
        step();
        checks++;
        if ({b_done, b_valid, b_busy} !== 3'b000) begin
            failures++;
            $display("FAIL single_idle got %b exp 000", {b_done, b_valid, b_busy});
        end
    endtask

    task automatic test_degenerate();
        do_reset();
        ready = 1'b1;
        pulse_start();
        checks++;
        if ({c_done, c_valid, c_busy} !== 3'b100) begin
            failures++;
            $display("FAIL degen_done got %b exp 100", {c_done, c_valid, c_busy});
        end
        step();
        checks++;
        if ({c_done, c_valid, c_busy} !== 3'b000) begin
            failures++;
            $display("FAIL degen_idle got %b exp 000", {c_done, c_valid, c_busy});
        end
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if ({a_valid, a_busy, c_done} !== 3'b000) begin
            failures++;
            $display("FAIL start_abort_idle got %b exp 000", {a_valid, a_busy, c_done});
        end
    endtask

    task automatic test_abort();
        do_reset();
        ready = 1'b1;
        pulse_start();
        repeat (4) step();
        checks++;
        if ({a_valid, a_i, a_j, a_k} !== {1'b1, 32'd0, 32'd1, 32'd1}) begin
            failures++;
            $display("FAIL abort_beat5 got %h exp %h", {a_valid, a_i, a_j, a_k}, {1'b1, 32'd0, 32'd1, 32'd1});
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if ({a_valid, a_busy, a_done, a_last, a_i, a_j, a_k} !== 100'd0) begin
            failures++;
            $display("FAIL abort_idle got %h exp 0", {a_valid, a_busy, a_done, a_last, a_i, a_j, a_k});
        end
        step();
        checks++;
        if ({a_done, a_valid} !== 2'b00) begin
            failures++;
            $display("FAIL abort_nodone got %b exp 00", {a_done, a_valid});
        end
        pulse_start();
        checks++;
        if ({a_valid, a_busy, a_i, a_j, a_k} !== {2'b11, 96'd0}) begin
            failures++;
            $display("FAIL abort_restart got %h exp %h", {a_valid, a_busy, a_i, a_j, a_k}, {2'b11, 96'd0});
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        ready = 1'b1;
        pulse_start();
        repeat (3) step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_valid, a_last, a_busy, a_done, a_i, a_j, a_k} !== 100'd0) begin
            failures++;
            $display("FAIL async_reset got %h exp 0", {a_valid, a_last, a_busy, a_done, a_i, a_j, a_k});
        end
        #1;
        rst_n = 1'b1;
        step();
        checks++;
        if ({a_valid, a_busy} !== 2'b00) begin
            failures++;
            $display("FAIL async_no_resume got %b exp 00", {a_valid, a_busy});
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        ready = 1'b1;
        pulse_start();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({b_valid, b_done} !== 2'b00) begin
            failures++;
            $display("FAIL b2b_idle got %b exp 00", {b_valid, b_done});
        end
        checks++;
        if ({a_valid, a_i, a_j, a_k} !== {1'b1, 32'd0, 32'd0, 32'd2}) begin
            failures++;
            $display("FAIL b2b_start_ignored got %h exp %h", {a_valid, a_i, a_j, a_k}, {1'b1, 32'd0, 32'd0, 32'd2});
        end
    endtask

`ifdef MMUL_SEQ_ACC_EN
    task automatic test_acc();
        do_reset();
        ready = 1'b1;
        pulse_start();
        for (int b = 1; b <= 6; b++) begin
            checks++;
            if ({d_valid, d_clr, d_com} !== {1'b1, (b == 1 || b == 4), (b == 3 || b == 6)}) begin
                failures++;
                $display("FAIL acc_beat%0d got %b exp %b", b, {d_valid, d_clr, d_com},
                         {1'b1, (b == 1 || b == 4), (b == 3 || b == 6)});
            end
            step();
        end
        checks++;
        if ({d_done, d_clr, d_com} !== 3'b100) begin
            failures++;
            $display("FAIL acc_done got %b exp 100", {d_done, d_clr, d_com});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sweep();
        test_ready_toggle();
        test_single();
        test_degenerate();
        test_abort();
        test_async_reset();
        test_back_to_back();
`ifdef MMUL_SEQ_ACC_EN
        test_acc();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mmul_index_sequencer.md
MMUL_INDEX_SEQUENCER -- requirements
Module: mmul_index_sequencer

Interface
REQ-001 Parameter RA, default 0: rows of matrix A; outer loop bound for i.
REQ-002 Parameter CA, default 0: columns of matrix A; shall equal RB.
REQ-003 Parameter RB, default 0: rows of matrix B; inner loop bound for k.
REQ-004 Parameter CB, default 0: columns of matrix B; middle loop bound for j.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  one-cycle request to begin a full i/j/k sweep; ignored unless in IDLE.
REQ-008 abort  input  1  terminates a sweep in progress; returns to IDLE.
REQ-009 ready  input  1  downstream accepts the current index beat.
REQ-010 valid  output  1  current i/j/k beat is valid.
REQ-011 i  output  32  row index of A, 0..RA-1.
REQ-012 j  output  32  column index of B, 0..CB-1.
REQ-013 k  output  32  reduction index, 0..RB-1.
REQ-014 last  output  1  high with valid on beat i==RA-1, j==CB-1, k==RB-1.
REQ-015 busy  output  1  high in RUN state.
REQ-016 done  output  1  one-cycle pulse after the last beat is accepted.

Function
REQ-017 FSM states IDLE, RUN, DONE; all outputs registered.
REQ-018 IDLE: start=1 -> RUN next cycle, i=j=k=0, valid=1.
REQ-019 Beat accepted on a rising edge with valid=1 and ready=1; no advance otherwise; i/j/k/valid/last held stable while valid=1 and ready=0.
REQ-020 Advance order: k increments; at k==RB-1 k wraps to 0 and j increments; at j==CB-1 j wraps to 0 and i increments.
REQ-021 Accepted beat with last=1 -> DONE, valid=0; DONE lasts exactly one cycle with done=1, then IDLE.
REQ-022 Back-to-back accepted beats sustain throughput of one beat per cycle while ready=1.
REQ-023 Index arithmetic 32-bit unsigned; comparisons against RA-1, CB-1, RB-1 evaluated at 32 bits.
REQ-024 Degenerate config (RA, RB or CB equal 0): start -> DONE next cycle with no valid beat, done pulse, then IDLE.
REQ-025 Single-element config (RA=RB=CB=1): first beat has last=1.
REQ-026 abort=1 in RUN or DONE -> IDLE next cycle, valid=0, done=0, indices cleared to 0; abort has priority over beat acceptance; abort in IDLE is a no-op.
REQ-027 start while RUN or DONE ignored; start and abort together in IDLE -> remain IDLE.
REQ-028 busy=1 exactly while in RUN.

Reset
REQ-029 rst_n=0 forces IDLE immediately, asynchronously, regardless of clk.
REQ-030 Reset values: valid=0, last=0, busy=0, done=0, i=j=k=0; acc_clr=0, acc_commit=0 when present.
REQ-031 Reset mid-sweep discards progress; a new start is required after release.

Configuration
REQ-032 Macro MMUL_SEQ_ACC_EN defined: output acc_clr (1 bit) high with valid on every beat where k==0; output acc_commit (1 bit) high with valid on every beat where k==RB-1; both obey the REQ-019 hold rule.
REQ-033 MMUL_SEQ_ACC_EN undefined: acc_clr and acc_commit ports and logic absent; all other behaviour identical.

Verification
REQ-034 RA=2,CB=2,RB=3, ready tied 1, start pulse -> 12 consecutive beats, k 0,1,2 per (i,j), (i,j) order (0,0),(0,1),(1,0),(1,1); last on beat 12; done one cycle later.
REQ-035 Same config, ready toggled 1,0 each cycle -> 12 beats, indices stable during ready=0 cycles, no skipped or duplicated beat.
REQ-036 RA=1,CB=1,RB=1, start -> single beat with last=1, then done pulse, then IDLE.
REQ-037 RA=2,CB=2,RB=3, abort on beat 5 with ready=1 -> IDLE next cycle, valid=0, no done pulse; subsequent start restarts at i=j=k=0.
REQ-038 rst_n driven low between clock edges mid-sweep -> all outputs at reset values before the next edge.
REQ-039 MMUL_SEQ_ACC_EN defined, RA=1,CB=2,RB=3 -> acc_clr on beats 1 and 4; acc_commit on beats 3 and 6.
